uart_rx_fc: RTL and testbench

UART receive engine with hardware flow control: deserialises 8-bit frames from `rxd` and buffers them in a small FIFO. It presents bytes to the core through the `rxData`/`rxDataReady`/`rxDataReq` handshake and drives `rts_n` from FIFO occupancy. It is the receive-side counterpart of the UART transmitter: it consumes what `txd` produces, and its `rts_n` feeds the peer's `cts_n`. The block is started and stopped by task pulses, in the same way as the rest of the UART.

---
 rtl/uart_rx_fc_if.sv | 12 +
 rtl/uart_rx_fc.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_rx_fc.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fc_if.sv
// uart_rx_fc_if: receive-data handshake between the UART receive engine
// and the core that consumes its bytes.
//   master: the receiver (drives the FIFO head and its valid flag)
//   slave : the consumer (requests a pop of the head byte)
interface uart_rx_fc_if;
  logic [7:0] rxData;
  logic       rxDataReady;
  logic       rxDataReq;

  modport master (output rxData, output rxDataReady, input rxDataReq);
  modport slave  (input rxData, input rxDataReady, output rxDataReq);
endinterface

// File: rtl/uart_rx_fc.sv
// uart_rx_fc: UART receive engine with hardware flow control.
// Deserialises 8-bit LSB-first frames from rxd using an OVERSAMPLE-times
// baud tick, buffers them in a small FIFO, presents them through the
// rxData/rxDataReady/rxDataReq handshake and drives rts_n from FIFO space.
// Optional feature macro: UART_RX_PARITY_EN adds one even-parity bit per
// frame (8E1); without it frames are 8N1 and errParity is tied low.
module uart_rx_fc #(
  parameter int OVERSAMPLE    = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int RTS_THRESHOLD = 2
) (
  input  logic         ck,
  input  logic         arst,
  input  logic         ckBrg,
  input  logic         rxd,
  input  logic         taskStartRx,
  input  logic         taskStopRx,
  uart_rx_fc_if.master rxIf,
  output logic         rts_n,
  output logic         uartRxEnable,
  output logic         eventRxDrdy,
  output logic         errFraming,
  output logic         errOverrun,
  output logic         errParity
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } rxState_t;

  rxState_t         state, stateNext;
  logic [CNT_W-1:0] tickCnt, tickCntNext;
  logic [2:0]       bitIdx, bitIdxNext;
  logic [7:0]       shiftReg, shiftRegNext;
  logic             pushReq;
  logic             framingPulse;
`ifdef UART_RX_PARITY_EN
  logic             parErr, parErrNext;
  logic             parityPulse;
`endif

  logic             rxdMeta, rxdS;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [OCC_W-1:0] count;
  logic             fifoFull, popOk, pushOk, overrun;

  // Two-flop synchroniser for the asynchronous serial input, idles high.
  // NOTE: sequential state always uses non-blocking (<=) so every flop
  // samples pre-edge values; blocking here would collapse the two stages.
  always_ff @(posedge ck or negedge arst) begin
    if (!arst) begin
      rxdMeta <= 1'b1;
      rxdS    <= 1'b1;
    end else begin
      rxdMeta <= rxd;
      rxdS    <= rxdMeta;
    end
  end

  // Receive FSM and bit-timing datapath registers.
  always_ff @(posedge ck or negedge arst) begin
    if (!arst) begin
      state    <= IDLE;
      tickCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
`ifdef UART_RX_PARITY_EN
      parErr   <= 1'b0;
`endif
    end else begin
      state    <= stateNext;
      tickCnt  <= tickCntNext;
      bitIdx   <= bitIdxNext;
      shiftReg <= shiftRegNext;
`ifdef UART_RX_PARITY_EN
      parErr   <= parErrNext;
`endif
    end
  end

  // Next-state, bit sampling and per-frame push/error decisions.
  // NOTE: every variable gets a default before the case so no path can
  // leave one unassigned, which would otherwise infer a latch.
  always_comb begin
    stateNext    = state;
    tickCntNext  = tickCnt;
    bitIdxNext   = bitIdx;
    shiftRegNext = shiftReg;
    pushReq      = 1'b0;
    framingPulse = 1'b0;
`ifdef UART_RX_PARITY_EN
    parErrNext   = parErr;
    parityPulse  = 1'b0;
`endif
    if (taskStopRx) begin
      // Stop wins over start and aborts any frame silently.
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE: if (taskStartRx) stateNext = WAIT_START;
        WAIT_START: if (ckBrg && !rxdS) begin
          stateNext   = START;
          tickCntNext = '0;
        end
        START: if (ckBrg) begin
          if (tickCnt == HALF_LAST) begin
            // Mid start bit: still low means a real start, else a glitch.
            tickCntNext = '0;
            bitIdxNext  = '0;
`ifdef UART_RX_PARITY_EN
            parErrNext  = 1'b0;
`endif
            stateNext   = rxdS ? WAIT_START : DATA;
          end else begin
            tickCntNext = tickCnt + 1'b1;
          end
        end
        DATA: if (ckBrg) begin
          if (tickCnt == FULL_LAST) begin
            tickCntNext  = '0;
            shiftRegNext = {rxdS, shiftReg[7:1]};
            bitIdxNext   = bitIdx + 1'b1;
            if (bitIdx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              stateNext = PARITY;
`else
              stateNext = STOP;
`endif
            end
          end else begin
            tickCntNext = tickCnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (ckBrg) begin
          if (tickCnt == FULL_LAST) begin
            tickCntNext = '0;
            stateNext   = STOP;
            if (rxdS != ^shiftReg) begin
              parErrNext  = 1'b1;
              parityPulse = 1'b1;
            end
          end else begin
            tickCntNext = tickCnt + 1'b1;
          end
        end
`endif
        STOP: if (ckBrg) begin
          if (tickCnt == FULL_LAST) begin
            tickCntNext = '0;
            if (rxdS) begin
`ifdef UART_RX_PARITY_EN
              pushReq = !parErr;
`else
              pushReq = 1'b1;
`endif
              stateNext = WAIT_START;
            end else begin
              framingPulse = 1'b1;
              stateNext    = BREAK;
            end
          end else begin
            tickCntNext = tickCnt + 1'b1;
          end
        end
        BREAK: if (rxdS) stateNext = WAIT_START;
        default: stateNext = IDLE;
      endcase
    end
  end

  assign uartRxEnable = (state != IDLE);

  // FIFO handshake: a pop frees a slot in the same cycle, so a push onto a
  // full FIFO with a simultaneous pop is accepted.
  assign fifoFull = (count == OCC_W'(FIFO_DEPTH));
  assign popOk    = rxIf.rxDataReq && (count != '0);
  assign pushOk   = pushReq && (!fifoFull || popOk);
  assign overrun  = pushReq && fifoFull && !popOk;

  // FIFO storage write port.
  // NOTE: the data array has no reset; it is never read while empty
  // because rxData is forced to zero whenever the FIFO holds nothing.
  always_ff @(posedge ck) begin
    if (pushOk) mem[wrPtr] <= shiftReg;
  end

  // FIFO pointers, occupancy, registered event pulses and flow control.
  always_ff @(posedge ck or negedge arst) begin
    if (!arst) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      eventRxDrdy <= 1'b0;
      errFraming  <= 1'b0;
      errOverrun  <= 1'b0;
      rts_n       <= 1'b1;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk)  rdPtr <= rdPtr + 1'b1;
      case ({pushOk, popOk})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      eventRxDrdy <= pushOk;
      errFraming  <= framingPulse;
      errOverrun  <= overrun;
      rts_n       <= !(uartRxEnable &&
                       ((OCC_W'(FIFO_DEPTH) - count) >= OCC_W'(RTS_THRESHOLD)));
    end
  end

`ifdef UART_RX_PARITY_EN
  // Registered parity-error pulse, aligned with the other event outputs.
  always_ff @(posedge ck or negedge arst) begin
    if (!arst) errParity <= 1'b0;
    else       errParity <= parityPulse;
  end
`else
  assign errParity = 1'b0;
`endif

  assign rxIf.rxDataReady = (count != '0);
  assign rxIf.rxData      = rxIf.rxDataReady ? mem[rdPtr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fc.sv
// tb_uart_rx_fc: self-checking bench for uart_rx_fc (OVERSAMPLE=16,
// FIFO_DEPTH=4, RTS_THRESHOLD=2). A table of fill vectors, hand-written
// corner sequences and a randomized run checked against a queue model.
module tb_uart_rx_fc;
  localparam int OVS     = 16;
  localparam int DEPTH   = 4;
  localparam int THR     = 2;
  localparam int BRG_DIV = 3;
  localparam int BIT_CYC = OVS * BRG_DIV;

  logic ck = 1'b0;
  logic arst = 1'b1;
  logic ckBrg = 1'b0;
  logic rxd = 1'b1;
  logic taskStartRx = 1'b0;
  logic taskStopRx = 1'b0;
  logic rts_n, uartRxEnable, eventRxDrdy, errFraming, errOverrun, errParity;

  uart_rx_fc_if rxBus ();

  uart_rx_fc #(.OVERSAMPLE(OVS), .FIFO_DEPTH(DEPTH), .RTS_THRESHOLD(THR)) dut (
    .ck(ck), .arst(arst), .ckBrg(ckBrg), .rxd(rxd),
    .taskStartRx(taskStartRx), .taskStopRx(taskStopRx),
    .rxIf(rxBus.master),
    .rts_n(rts_n), .uartRxEnable(uartRxEnable), .eventRxDrdy(eventRxDrdy),
    .errFraming(errFraming), .errOverrun(errOverrun), .errParity(errParity)
  );

  int nChecks = 0;
  int nErrors = 0;
  int nDrdy = 0, nFrm = 0, nOvr = 0, nPar = 0;
  int bD, bF, bO, bP;
  int brgCnt = 0;
  logic [7:0] model [$];

  typedef struct {
    logic [7:0] data;
    int         expDrdy;
    int         expOvr;
    logic [7:0] expHead;
    logic       expRts;
  } fillVec_t;
  fillVec_t fillVec [5];

  always #5 ck = ~ck;

  always @(negedge ck) begin
    brgCnt = (brgCnt == BRG_DIV - 1) ? 0 : brgCnt + 1;
    ckBrg  = (brgCnt == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge ck) begin
    if (eventRxDrdy) nDrdy++;
    if (errFraming)  nFrm++;
    if (errOverrun)  nOvr++;
    if (errParity)   nPar++;
    if (eventRxDrdy) check("drdy_with_ready", rxBus.rxDataReady, 1'b1);
  end

  task automatic snap();
    bD = nDrdy; bF = nFrm; bO = nOvr; bP = nPar;
  endtask

  task automatic checkDeltas(input string tag, input int d, input int f, input int o);
    check({tag, "_drdy"}, nDrdy - bD, d);
    check({tag, "_framing"}, nFrm - bF, f);
    check({tag, "_overrun"}, nOvr - bO, o);
  endtask

  task automatic holdBit(input logic v);
    rxd = v;
    repeat (BIT_CYC) @(negedge ck);
  endtask

  task automatic rawFrame(input logic [7:0] b, input logic par, input logic stopBit);
    holdBit(1'b0);
    for (int i = 0; i < 8; i++) holdBit(b[i]);
`ifdef UART_RX_PARITY_EN
    holdBit(par);
`else
    if (par === 1'bx) rxd = 1'b1;
`endif
    holdBit(stopBit);
    rxd = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] b);
    rawFrame(b, ^b, 1'b1);
  endtask

  task automatic popExpect(input logic [7:0] exp, input string tag);
    check({tag, "_ready"}, rxBus.rxDataReady, 1'b1);
    check({tag, "_data"}, rxBus.rxData, exp);
    rxBus.rxDataReq = 1'b1;
    @(negedge ck);
    rxBus.rxDataReq = 1'b0;
  endtask

  task automatic pulseStart();
    taskStartRx = 1'b1;
    @(negedge ck);
    taskStartRx = 1'b0;
  endtask

  function automatic logic expRts();
    return !((DEPTH - model.size()) >= THR);
  endfunction

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nPop;
    logic [7:0] b;
    bit bad;

    fillVec[0] = '{8'h01, 1, 0, 8'h01, 1'b0};
    fillVec[1] = '{8'h02, 1, 0, 8'h01, 1'b0};
    fillVec[2] = '{8'h03, 1, 0, 8'h01, 1'b1};
    fillVec[3] = '{8'h04, 1, 0, 8'h01, 1'b1};
    fillVec[4] = '{8'h05, 0, 1, 8'h01, 1'b1};

    rxBus.rxDataReq = 1'b0;
    repeat (2) @(negedge ck);
    arst = 1'b0;
    repeat (3) @(negedge ck);
    check("rst_rxData", rxBus.rxData, 8'h00);
    check("rst_ready", rxBus.rxDataReady, 1'b0);
    check("rst_rts", rts_n, 1'b1);
    check("rst_enable", uartRxEnable, 1'b0);
    check("rst_pulses", {eventRxDrdy, errFraming, errOverrun, errParity}, 4'b0);
    arst = 1'b1;
    repeat (2) @(negedge ck);

    // Enable latency: uartRxEnable one cycle, rts_n one further cycle.
    pulseStart();
    check("start_enable", uartRxEnable, 1'b1);
    check("start_rts_lat", rts_n, 1'b1);
    @(negedge ck);
    check("start_rts", rts_n, 1'b0);

    // Pop request while empty is ignored.
    rxBus.rxDataReq = 1'b1;
    @(negedge ck);
    rxBus.rxDataReq = 1'b0;
    check("empty_req_ready", rxBus.rxDataReady, 1'b0);

    // Single frame 0xA5.
    snap();
    sendFrame(8'hA5);
    checkDeltas("a5", 1, 0, 0);
    check("a5_rts", rts_n, 1'b0);
    popExpect(8'hA5, "a5_pop");
    check("a5_empty", rxBus.rxDataReady, 1'b0);

    // Fill past capacity without pops.
    for (int i = 0; i < 5; i++) begin
      snap();
      sendFrame(fillVec[i].data);
      checkDeltas($sformatf("fill%0d", i), fillVec[i].expDrdy, 0, fillVec[i].expOvr);
      check($sformatf("fill%0d_head", i), rxBus.rxData, fillVec[i].expHead);
      check($sformatf("fill%0d_rts", i), rts_n, fillVec[i].expRts);
    end
    for (int i = 1; i <= 4; i++) popExpect(8'(i), $sformatf("drain%0d", i));
    check("drain_empty", rxBus.rxDataReady, 1'b0);
    @(negedge ck);
    check("drain_rts", rts_n, 1'b0);

    // Stop bit held low for 20 bit-times, then a good frame.
    snap();
    rawFrame(8'h55, ^8'h55, 1'b0);
    rxd = 1'b0;
    repeat (19 * BIT_CYC) @(negedge ck);
    rxd = 1'b1;
    repeat (BIT_CYC) @(negedge ck);
    checkDeltas("break", 0, 1, 0);
    check("break_ready", rxBus.rxDataReady, 1'b0);
    snap();
    sendFrame(8'h3C);
    checkDeltas("after_break", 1, 0, 0);
    popExpect(8'h3C, "after_break_pop");

    // Short low glitch on idle line is a false start.
    snap();
    rxd = 1'b0;
    repeat (3 * BRG_DIV) @(negedge ck);
    rxd = 1'b1;
    repeat (2 * BIT_CYC) @(negedge ck);
    checkDeltas("glitch", 0, 0, 0);
    check("glitch_enable", uartRxEnable, 1'b1);
    sendFrame(8'hC3);
    checkDeltas("glitch_then", 1, 0, 0);
    popExpect(8'hC3, "glitch_pop");

    // Stop mid-frame with one byte buffered.
    sendFrame(8'h5A);
    snap();
    fork
      rawFrame(8'hFF, ^8'hFF, 1'b1);
      begin
        repeat (4 * BIT_CYC) @(negedge ck);
        taskStopRx = 1'b1;
        @(negedge ck);
        taskStopRx = 1'b0;
        check("stop_enable", uartRxEnable, 1'b0);
        check("stop_rts_lat", rts_n, 1'b0);
        @(negedge ck);
        check("stop_rts", rts_n, 1'b1);
      end
    join
    checkDeltas("stop", 0, 0, 0);
    popExpect(8'h5A, "stop_pop");
    check("stop_empty", rxBus.rxDataReady, 1'b0);
    taskStartRx = 1'b1;
    taskStopRx  = 1'b1;
    @(negedge ck);
    taskStartRx = 1'b0;
    taskStopRx  = 1'b0;
    @(negedge ck);
    check("startstop_enable", uartRxEnable, 1'b0);
    check("startstop_rts", rts_n, 1'b1);
    pulseStart();
    @(negedge ck);

`ifdef UART_RX_PARITY_EN
    snap();
    rawFrame(8'h07, 1'b0, 1'b1);
    checkDeltas("par_bad", 0, 0, 0);
    check("par_bad_pulse", nPar - bP, 1);
    check("par_bad_ready", rxBus.rxDataReady, 1'b0);
    snap();
    rawFrame(8'h07, 1'b1, 1'b1);
    checkDeltas("par_good", 1, 0, 0);
    check("par_good_pulse", nPar - bP, 0);
    popExpect(8'h07, "par_pop");
`endif

    // Randomized frames and pops against the queue model.
    for (int it = 0; it < 24; it++) begin
      nPop = $urandom_range(0, 2);
      b    = 8'($urandom_range(0, 255));
      for (int p = 0; p < nPop; p++) begin
        if (model.size() != 0) begin
          popExpect(model[0], "rnd_pop");
          void'(model.pop_front());
        end else begin
          rxBus.rxDataReq = 1'b1;
          @(negedge ck);
          rxBus.rxDataReq = 1'b0;
          check("rnd_empty_req", rxBus.rxDataReady, 1'b0);
        end
      end
      @(negedge ck);
      check("rnd_rts_pre", rts_n, expRts());
      bad = ($urandom_range(0, 6) == 0);
      snap();
      if (bad) begin
        rawFrame(b, ^b, 1'b0);
        rxd = 1'b0;
        repeat ($urandom_range(0, 3) * BIT_CYC) @(negedge ck);
        rxd = 1'b1;
        repeat (BIT_CYC) @(negedge ck);
        checkDeltas("rnd_bad", 0, 1, 0);
      end else begin
        sendFrame(b);
        if (model.size() < DEPTH) begin
          model.push_back(b);
          checkDeltas("rnd_ok", 1, 0, 0);
        end else begin
          checkDeltas("rnd_full", 0, 0, 1);
        end
      end
      check("rnd_ready", rxBus.rxDataReady, model.size() != 0);
      if (model.size() != 0) check("rnd_head", rxBus.rxData, model[0]);
      check("rnd_rts", rts_n, expRts());
    end
    while (model.size() != 0) begin
      popExpect(model[0], "rnd_drain");
      void'(model.pop_front());
    end
    check("rnd_drain_empty", rxBus.rxDataReady, 1'b0);

    // Asynchronous reset mid-frame with a byte buffered.
    sendFrame(8'h69);
    fork
      rawFrame(8'hE1, ^8'hE1, 1'b1);
      begin
        repeat (3 * BIT_CYC) @(negedge ck);
        arst = 1'b0;
        #1;
        check("arst_ready", rxBus.rxDataReady, 1'b0);
        check("arst_rxData", rxBus.rxData, 8'h00);
        check("arst_enable", uartRxEnable, 1'b0);
        check("arst_rts", rts_n, 1'b1);
        repeat (2) @(negedge ck);
        arst = 1'b1;
      end
    join
    pulseStart();
    snap();
    sendFrame(8'h96);
    checkDeltas("post_arst", 1, 0, 0);
    popExpect(8'h96, "post_arst_pop");
    check("post_arst_empty", rxBus.rxDataReady, 1'b0);

`ifndef UART_RX_PARITY_EN
    check("no_parity_pulses", nPar, 0);
`endif

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
